// File: rtl/seq_match_ctrl.sv
// Serial pattern detector: one run compares a bit stream against a latched 1..8 bit pattern,
// counting matches until an optional limit is reached or the run is aborted.
module seq_match_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic [7:0]       cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: a bit is consumed on every rising edge in RUN where x_valid=1; there is no
  // backpressure, and start/ack are single-cycle requests sampled in IDLE/DONE respectively.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       hist;
  logic [7:0]       pat;
  logic [3:0]       fill;
  logic [2:0]       len_m1;
  logic             ovl;
  logic [CNT_W-1:0] lim;

  logic [7:0]       cand;
  logic [7:0]       mask;
  logic             match;
  logic             hit_limit;
  logic [CNT_W:0]   cnt_inc;

  // Candidate window is the previous bits plus the live bit; only the low len bits are compared.
  always_comb begin
    cand      = {hist[6:0], x};
    mask      = 8'hFF >> (3'd7 - len_m1);
    match     = (state == S_RUN) && x_valid && !abort &&
                (fill >= {1'b0, len_m1}) && (((cand ^ pat) & mask) == 8'h00);
    cnt_inc   = {1'b0, match_cnt} + {{CNT_W{1'b0}}, 1'b1};
    hit_limit = match && (lim != '0) && (cnt_inc == {1'b0, lim});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (hit_limit) state_nxt = S_DONE;
      end
      S_DONE: if (ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign z         = match && !reset;
  assign busy      = (state == S_RUN) && !reset;
  assign done      = (state == S_DONE) && !reset;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hist      <= 8'h00;
      fill      <= 4'd0;
      match_cnt <= '0;
      pat       <= 8'h00;
      len_m1    <= 3'd0;
      ovl       <= 1'b0;
      lim       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat       <= cfg_pattern;
            len_m1    <= cfg_len;
            ovl       <= cfg_overlap;
            lim       <= cfg_limit;
            hist      <= 8'h00;
            fill      <= 4'd0;
            match_cnt <= '0;
          end
        end
        S_RUN: begin
          if (x_valid && !abort) begin
            hist <= cand;
            // Non-overlapping mode restarts the fill so no bit is shared between matches.
            if (match && !ovl)   fill <= 4'd0;
            else if (fill != 4'd8) fill <= fill + 4'd1;
            if (match && (match_cnt != '1)) match_cnt <= cnt_inc[CNT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios plus random traffic, all checked against a
// bit-queue reference model that tracks the run by the detector's rules.
module tb_seq_match_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             ack;
  logic [7:0]       cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             x;
  logic             x_valid;
  logic             z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state_dbg;

  seq_match_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_limit(cfg_limit), .x(x), .x_valid(x_valid), .z(z), .busy(busy),
    .done(done), .match_cnt(match_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int zhits    = 0;

  // Reference model: phase 0 idle, 1 running, 2 finished.
  int         m_phase = 0;
  bit [7:0]   m_pat   = 8'h00;
  int         m_len   = 1;
  bit         m_ovl   = 1'b0;
  int         m_lim   = 0;
  int         m_cnt   = 0;
  bit         bq[$];
  logic [0:0] exp_q[$];

  function automatic bit model_match(bit xb);
    bit b;
    if (bq.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == m_len - 1) ? xb : bq[bq.size() - (m_len - 1) + i];
      if (b != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Driver: one clock cycle of stimulus, checked against the model before and after the edge.
  task automatic cycle(input bit rst, input bit st, input bit ab, input bit ak,
                       input bit xv, input bit xb);
    bit       ez;
    logic [0:0] e;
    @(negedge clk);
    reset = rst; start = st; abort = ab; ack = ak; x_valid = xv; x = xb;
    ez = !rst && (m_phase == 1) && xv && !ab && model_match(xb);
    exp_q.push_back(ez);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (z !== e[0]) begin
      n_fails++;
      $display("FAIL z t=%0t actual=%b required=%b", $time, z, e[0]);
    end
    n_checks++;
    if (busy !== (!rst && m_phase == 1)) begin
      n_fails++;
      $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, (!rst && m_phase == 1));
    end
    n_checks++;
    if (done !== (!rst && m_phase == 2)) begin
      n_fails++;
      $display("FAIL done t=%0t actual=%b required=%b", $time, done, (!rst && m_phase == 2));
    end
    if (z === 1'b1) zhits++;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_pat = 8'h00; m_len = 1; m_ovl = 1'b0; m_lim = 0; m_cnt = 0;
      bq.delete();
    end else if (m_phase == 0) begin
      if (st) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len) + 1; m_ovl = cfg_overlap;
        m_lim = int'(cfg_limit); m_cnt = 0; bq.delete(); m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ab) m_phase = 0;
      else if (xv) begin
        if (ez) begin
          if (m_cnt < 255) m_cnt++;
          if (m_ovl) bq.push_back(xb);
          else bq.delete();
          if (m_lim != 0 && m_cnt == m_lim) m_phase = 2;
        end else begin
          bq.push_back(xb);
        end
        if (bq.size() > 8) void'(bq.pop_front());
      end
    end else begin
      if (ak) m_phase = 0;
    end
    #1;
    n_checks++;
    if (match_cnt !== CNT_W'(m_cnt)) begin
      n_fails++;
      $display("FAIL match_cnt t=%0t actual=%0d required=%0d", $time, match_cnt, m_cnt);
    end
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [2:0] l, input logic o,
                         input logic [CNT_W-1:0] lm);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_limit = lm;
  endtask

  task automatic expect_val(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fails++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    expect_val("reset_busy", int'(busy), 0);
    expect_val("reset_cnt", int'(match_cnt), 0);
  endtask

  task automatic test_no_overlap();
    set_cfg(8'b0000_0111, 3'd2, 1'b0, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    set_cfg(8'hFF, 3'd0, 1'b1, 8'd1);  // must not affect the running config
    zhits = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1);
    expect_val("no_overlap_zhits", zhits, 2);
    expect_val("no_overlap_cnt", int'(match_cnt), 2);
    cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_overlap();
    set_cfg(8'b0000_0111, 3'd2, 1'b1, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    zhits = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1);
    expect_val("overlap_zhits", zhits, 4);
    expect_val("overlap_cnt", int'(match_cnt), 4);
    cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_limit();
    bit [5:0] s;
    s = 6'b110110;
    set_cfg(8'b0000_0110, 3'd2, 1'b0, 8'd2);
    cycle(0, 1, 0, 0, 0, 0);
    zhits = 0;
    for (int i = 5; i >= 0; i--) cycle(0, 0, 0, 0, 1, s[i]);
    expect_val("limit_zhits", zhits, 2);
    cycle(0, 1, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    expect_val("limit_done_held", int'(done), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    expect_val("limit_idle_busy", int'(busy), 0);
    expect_val("limit_cnt_kept", int'(match_cnt), 2);
  endtask

  task automatic test_gaps_abort();
    set_cfg(8'b0000_0101, 3'd2, 1'b1, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    zhits = 0;
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    expect_val("gap_zhits", zhits, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    expect_val("abort_zhits", zhits, 1);
    expect_val("abort_cnt", int'(match_cnt), 1);
    expect_val("abort_busy", int'(busy), 0);
  endtask

  task automatic test_reset_midrun();
    set_cfg(8'b0000_0011, 3'd1, 1'b1, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1);
    expect_val("midrun_cnt_before", int'(match_cnt), 2);
    cycle(1, 1, 1, 1, 1, 1);
    expect_val("midrun_cnt_after", int'(match_cnt), 0);
    set_cfg(8'b0000_0000, 3'd0, 1'b0, 8'd0);
    cycle(0, 1, 0, 0, 0, 0);
    zhits = 0;
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    expect_val("restart_zhits", zhits, 2);
    cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_len1_limit();
    set_cfg(8'b0000_0001, 3'd0, 1'b0, 8'd255);
    cycle(0, 1, 0, 0, 0, 0);
    zhits = 0;
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 0, 1, 1);
    expect_val("len1_zhits", zhits, 255);
    expect_val("len1_done", int'(done), 1);
    expect_val("len1_cnt", int'(match_cnt), 255);
    cycle(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      set_cfg(8'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              CNT_W'($urandom_range(0, 6)));
      cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
        set_cfg(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                CNT_W'($urandom_range(0, 3)));
        cycle(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
      end
      cycle(0, 0, 1, 1, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; x = 1'b0; x_valid = 1'b0;
    set_cfg(8'h00, 3'd0, 1'b0, 8'd0);
    test_reset();
    test_no_overlap();
    test_overlap();
    test_limit();
    test_gaps_abort();
    test_reset_midrun();
    test_len1_limit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
